x_multdiv_unit: RTL and testbench

//  Multicycle mul/div engine in the execute stage. Consumes DX latch outputs
//  (ir, a, b) and produces the result and IR presented to the XM latch.

---
 rtl/x_multdiv_unit_pkg.sv | 43 ++++
 rtl/x_multdiv_unit_md_iter_dp.sv | 49 ++++
 rtl/x_multdiv_unit.sv | 143 ++++++++++++++
 tb/tb_x_multdiv_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_multdiv_unit_pkg.sv
// ISA constants, FSM encoding and decode helpers for the execute-stage
// multicycle mul/div engine.
package x_multdiv_unit_pkg;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    localparam logic [4:0] OPC_RTYPE   = 5'b00000;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;
    localparam int         RSTATUS_MUL = 4;
    localparam int         RSTATUS_DIV = 5;
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

    function automatic logic isMulDiv(input logic [31:0] ir);
        return (ir[OPC_HI:OPC_LO] == OPC_RTYPE) &&
               ((ir[ALUOP_HI:ALUOP_LO] == ALU_MUL) ||
                (ir[ALUOP_HI:ALUOP_LO] == ALU_DIV));
    endfunction

    function automatic logic isDivOp(input logic [31:0] ir);
        return ir[ALUOP_HI:ALUOP_LO] == ALU_DIV;
    endfunction

    function automatic logic [31:0] withRd(input logic [31:0] ir,
                                           input logic [4:0]  rd);
        logic [31:0] r;
        r = ir;
        r[RD_HI:RD_LO] = rd;
        return r;
    endfunction

endpackage

// File: rtl/x_multdiv_unit_md_iter_dp.sv
// Iterative mul/div datapath: one shift-add or restoring-divide step
// per cycle on unsigned magnitudes held in a double-width accumulator.
module md_iter_dp #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic           isDiv,
    input  logic [W-1:0]   opA,
    input  logic [W-1:0]   opB,
    output logic [2*W-1:0] accNext
);

    logic [2*W-1:0] acc;
    logic [W-1:0]   opReg;
    logic [W:0]     mulSum;
    logic [W:0]     remSh;
    logic [W-1:0]   remSub;
    logic           fits;

    // Low half starts as multiplier (mul) or dividend (div); the high
    // half accumulates partial product or partial remainder.
    always_comb begin
        mulSum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opReg} : '0);
        remSh   = acc[2*W-1:W-1];
        fits    = remSh >= {1'b0, opReg};
        remSub  = remSh[W-1:0] - opReg;
        accNext = {mulSum, acc[W-1:1]};
        if (isDiv) begin
            if (fits) accNext = {remSub, acc[W-2:0], 1'b1};
            else      accNext = {remSh[W-1:0], acc[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            opReg <= '0;
        end else if (load) begin
            acc   <= {{W{1'b0}}, opA};
            opReg <= opB;
        end else if (step) begin
            acc   <= accNext;
        end
    end

endmodule

// File: rtl/x_multdiv_unit.sv
// Execute-stage multicycle mul/div: stalls the front of the pipe while
// iterating, then presents result and IR (rewritten on exception) to XM.
module x_multdiv_unit
    import x_multdiv_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             stall,
    output logic             md_valid,
    output logic [WIDTH-1:0] result_out,
    output logic [31:0]      ir_out,
    output logic             exception
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdState_t             state;
    logic [ITER_BITS-1:0] cnt;
    logic [31:0]          irReg;
    logic [31:0]          irOutReg;
    logic [WIDTH-1:0]     resultReg;
    logic                 signReg;
    logic                 isDivReg;
    logic                 divExcReg;
    logic                 excReg;

    logic                 isMd;
    logic                 opDiv;
    logic                 lastIter;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [2*WIDTH-1:0]   accNext;
    logic [2*WIDTH-1:0]   mulSigned;
    logic [WIDTH:0]       mulHi;
    logic [WIDTH-1:0]     quot;
    logic                 mulOvf;
    logic                 finExc;
    logic [WIDTH-1:0]     finResult;

    assign isMd     = isMulDiv(ir_in);
    assign opDiv    = isDivOp(ir_in);
    assign magA     = a_in[WIDTH-1] ? -a_in : a_in;
    assign magB     = b_in[WIDTH-1] ? -b_in : b_in;
    assign lastIter = cnt == ITER_BITS'(WIDTH - 1);

    md_iter_dp #(.W(WIDTH)) uDp (
        .clk     (clk),
        .reset   (reset),
        .load    (state == MD_IDLE && isMd),
        .step    (state == MD_BUSY),
        .isDiv   (isDivReg),
        .opA     (magA),
        .opB     (magB),
        .accNext (accNext)
    );

    // Final result is formed from the last step's value so it can be
    // registered on the same edge that enters DONE.
    always_comb begin
        mulSigned = signReg ? -accNext : accNext;
        mulHi     = mulSigned[2*WIDTH-1:WIDTH-1];
        mulOvf    = !((&mulHi) || !(|mulHi));
        quot      = signReg ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
        finExc    = isDivReg ? divExcReg : mulOvf;
        finResult = isDivReg ? quot : mulSigned[WIDTH-1:0];
        if (finExc)
            finResult = isDivReg ? WIDTH'(RSTATUS_DIV) : WIDTH'(RSTATUS_MUL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            irReg     <= '0;
            irOutReg  <= '0;
            resultReg <= '0;
            signReg   <= 1'b0;
            isDivReg  <= 1'b0;
            divExcReg <= 1'b0;
            excReg    <= 1'b0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (isMd) begin
                        state     <= MD_BUSY;
                        cnt       <= '0;
                        irReg     <= ir_in;
                        signReg   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        isDivReg  <= opDiv;
                        divExcReg <= opDiv && ((b_in == '0) ||
                                     (a_in == MIN_NEG && b_in == '1));
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (lastIter) begin
                        state     <= MD_DONE;
                        excReg    <= finExc;
                        resultReg <= finResult;
                        irOutReg  <= finExc ? withRd(irReg, REG_RSTATUS)
                                            : irReg;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    always_comb begin
        stall      = 1'b0;
        md_valid   = 1'b0;
        result_out = '0;
        ir_out     = ir_in;
        exception  = 1'b0;
        unique case (state)
            MD_IDLE: begin
                if (isMd) begin
                    stall  = 1'b1;
                    ir_out = '0;
                end
            end
            MD_BUSY: begin
                stall  = 1'b1;
                ir_out = '0;
            end
            MD_DONE: begin
                md_valid   = 1'b1;
                result_out = resultReg;
                ir_out     = irOutReg;
                exception  = excReg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_x_multdiv_unit.sv
// Self-checking bench for x_multdiv_unit: vector table, model-driven
// random ops, reset-abort and back-to-back issue sequences.
module tb_x_multdiv_unit;
    import x_multdiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        stall;
    logic        md_valid;
    logic [31:0] result_out;
    logic [31:0] ir_out;
    logic        exception;

    typedef struct {
        bit          isDiv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] ir;
        bit          exc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    x_multdiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ir_in      (ir_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .stall      (stall),
        .md_valid   (md_valid),
        .result_out (result_out),
        .ir_out     (ir_out),
        .exception  (exception)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mkIr(input logic [4:0] aluop,
                                         input logic [4:0] rd);
        return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    function automatic void model(input bit isDiv, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] res, output bit exc);
        longint p;
        int     q;
        if (!isDiv) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            exc = (p > longint'(32'sh7FFF_FFFF)) ||
                  (p < longint'($signed(32'h8000_0000)));
            res = exc ? 32'd4 : p[31:0];
        end else if (b == 32'd0 ||
                     (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            exc = 1'b1;
            res = 32'd5;
        end else begin
            q   = $signed(a) / $signed(b);
            exc = 1'b0;
            res = q;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input bit isDiv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input bit exc, input logic [4:0] rd,
                         input bit scramble);
        exp_t        e;
        exp_t        got;
        logic [31:0] ir;
        logic [4:0]  op;
        bit          seen;
        bit          stallOk;
        seen    = 1'b0;
        stallOk = 1'b1;
        op      = isDiv ? ALU_DIV : ALU_MUL;
        ir      = mkIr(op, rd);
        e.res   = res;
        e.exc   = exc;
        e.ir    = exc ? mkIr(op, REG_RSTATUS) : ir;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        ir_in = ir;
        a_in  = a;
        b_in  = b;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (md_valid === 1'b1) begin
                seen = 1'b1;
                got  = sbq.pop_front();
                chk("result", result_out, got.res);
                chk("exception", 32'(exception), 32'(got.exc));
                chk("irOut", ir_out, got.ir);
                chk("latency", 32'(c), 32'd33);
                chk("doneStall", 32'(stall), 32'd0);
            end else begin
                if (stall !== 1'b1 || ir_out !== 32'd0) stallOk = 1'b0;
                if (scramble && c > 0) begin
                    a_in  = $urandom;
                    b_in  = $urandom;
                    ir_in = $urandom;
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: md_valid got 0 expected 1 within 40 cycles");
            void'(sbq.pop_front());
        end
        chk("stallPhase", 32'(stallOk), 32'd1);
    endtask

    vec_t        tbl[16];
    logic [31:0] addIr;
    logic [31:0] r;
    bit          x;
    bit          partial;

    initial begin
        tbl[0]  = '{0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 0};
        tbl[1]  = '{1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0};
        tbl[2]  = '{0, 32'h0001_0000,  32'h0001_0000, 32'd4,         1};
        tbl[3]  = '{0, 32'h4000_0000,  32'd2,         32'd4,         1};
        tbl[4]  = '{1, 32'd5,          32'd0,         32'd5,         1};
        tbl[5]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd5,         1};
        tbl[6]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         0};
        tbl[7]  = '{0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0};
        tbl[8]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd4,         1};
        tbl[9]  = '{1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0};
        tbl[10] = '{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         0};
        tbl[11] = '{1, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         0};
        tbl[12] = '{1, 32'h8000_0000,  32'd1,         32'h8000_0000, 0};
        tbl[13] = '{0, 32'd0,          32'hFFFF_FFFF, 32'd0,         0};
        tbl[14] = '{1, 32'd0,          32'd5,         32'd0,         0};
        tbl[15] = '{0, 32'h0000_FFFF,  32'h0000_8000, 32'h7FFF_8000, 0};

        addIr = mkIr(5'b00000, 5'd9);
        reset = 1'b1;
        ir_in = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstStall", 32'(stall), 32'd0);
        chk("rstValid", 32'(md_valid), 32'd0);
        chk("rstResult", result_out, 32'd0);
        chk("rstIrOut", ir_out, 32'd0);
        chk("rstExc", 32'(exception), 32'd0);

        for (int i = 0; i < 16; i++)
            issue(tbl[i].isDiv, tbl[i].a, tbl[i].b, tbl[i].res,
                  tbl[i].exc, 5'(i + 1), i[0]);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = 32'($signed($urandom) >>> $urandom_range(0, 31));
            rb = 32'($signed(32'($urandom_range(0, 600))) - 300);
            model(i[0], ra, rb, r, x);
            issue(i[0], ra, rb, r, x, 5'd11, 1'b1);
        end

        // Abort a mul mid-iteration with reset.
        @(posedge clk);
        #1;
        ir_in = mkIr(ALU_MUL, 5'd3);
        a_in  = 32'd3;
        b_in  = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        ir_in = addIr;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abortStall", 32'(stall), 32'd0);
        chk("abortValid", 32'(md_valid), 32'd0);
        chk("abortIrOut", ir_out, addIr);
        partial = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (md_valid !== 1'b0 || stall !== 1'b0) partial = 1'b1;
        end
        chk("noPartial", 32'(partial), 32'd0);
        issue(0, 32'd9, 32'd11, 32'd99, 0, 5'd4, 1'b0);

        // add passes straight through, then mul and div back-to-back.
        @(posedge clk);
        #1;
        ir_in = addIr;
        a_in  = 32'd1;
        b_in  = 32'd2;
        @(negedge clk);
        chk("addStall", 32'(stall), 32'd0);
        chk("addIrOut", ir_out, addIr);
        chk("addValid", 32'(md_valid), 32'd0);
        issue(0, 32'd12, 32'hFFFF_FFFD, 32'hFFFF_FFDC, 0, 5'd6, 1'b0);
        issue(1, 32'd100, 32'd9, 32'd11, 0, 5'd7, 1'b0);

        @(posedge clk);
        #1;
        ir_in = '0;
        @(negedge clk);
        chk("idleStall", 32'(stall), 32'd0);
        chk("sbEmpty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
